// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot serial TDM frame demultiplexer with sync hunt/lock.
// Optional TDM_DEMUX_PARITY_EN adds an even-parity slot 4 and drives parity_err.
module tdm_demux4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin_valid,
    input  logic       sin_data,
    input  logic       sin_sync,
    output logic [3:0] out,
    output logic       out_valid,
    output logic       lock,
    output logic       sync_err,
    output logic       parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [2:0] LAST_SLOT = 3'd4;
`else
    localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

    typedef enum logic {HUNT, RECV} state_t;

    state_t     state_q;
    logic [2:0] slot_q;
    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
    logic [3:0] out_q;
    logic       out_valid_q;
    logic       sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    logic       parity_err_q;
`endif

    // Slot k lands in bit 3-k; the parity slot never writes the shadow.
    always_comb begin
        shadow_d = shadow_q;
        if (slot_q <= 3'd3) begin
            shadow_d[2'd3 - slot_q[1:0]] = sin_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= 3'd0;
            shadow_q     <= 4'b0000;
            out_q        <= 4'b0000;
            out_valid_q  <= 1'b0;
            sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            out_valid_q  <= 1'b0;
            sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (sin_valid) begin
                case (state_q)
                    HUNT: begin
                        if (sin_sync) begin
                            state_q  <= RECV;
                            shadow_q <= {sin_data, 3'b000};
                            slot_q   <= 3'd1;
                        end
                    end
                    RECV: begin
                        if (slot_q == 3'd0 && !sin_sync) begin
                            sync_err_q <= 1'b1;
                            state_q    <= HUNT;
                            shadow_q   <= 4'b0000;
                        end else if (slot_q != 3'd0 && sin_sync) begin
                            // Early sync: drop the partial frame, restart on this beat.
                            sync_err_q <= 1'b1;
                            shadow_q   <= {sin_data, 3'b000};
                            slot_q     <= 3'd1;
                        end else if (slot_q == LAST_SLOT) begin
`ifdef TDM_DEMUX_PARITY_EN
                            out_q        <= shadow_q;
                            parity_err_q <= ^{shadow_q, sin_data};
`else
                            out_q        <= shadow_d;
`endif
                            out_valid_q <= 1'b1;
                            slot_q      <= 3'd0;
                            shadow_q    <= 4'b0000;
                        end else begin
                            shadow_q <= shadow_d;
                            slot_q   <= slot_q + 3'd1;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign lock      = (state_q == RECV);
    assign sync_err  = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have no parameters; lane count is fixed at 4 and slot count at 4 (5 with TDM_DEMUX_PARITY_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sin_valid, input, 1 bit: high when the serial beat on sin_data/sin_sync is valid this cycle.
REQ-005 The block SHALL have port sin_data, input, 1 bit: the serial slot bit.
REQ-006 The block SHALL have port sin_sync, input, 1 bit: frame marker, high only with the slot-0 beat.
REQ-007 The block SHALL have port out, output, 4 bits: the last completed frame, registered.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse when out updates.
REQ-009 The block SHALL have port lock, output, 1 bit: high while in state RECV.
REQ-010 The block SHALL have port sync_err, output, 1 bit: a one-cycle pulse on a framing violation.
REQ-011 The block SHALL have port parity_err, output, 1 bit: a one-cycle pulse on a parity mismatch; it is tied 0 without TDM_DEMUX_PARITY_EN.

Function
REQ-012 Slot mapping SHALL be slot k -> out[3-k] (slot 0 -> out[3], slot 3 -> out[0]), matching the team's 4:1 mux select order.
REQ-013 The FSM SHALL have states HUNT and RECV, with a slot counter (0..3, or 0..4 with parity).
REQ-014 In HUNT, valid beats with sin_sync=0 SHALL be discarded with no error.
REQ-015 In HUNT, a valid beat with sin_sync=1 SHALL be captured as slot 0, set the counter to 1, and move the FSM to RECV.
REQ-016 Cycles with sin_valid=0 SHALL NOT advance the counter or change state; inter-beat gaps are unbounded.
REQ-017 In RECV, each valid beat SHALL be captured into a shadow register at the current slot, and the counter SHALL increment.
REQ-018 On capture of the final slot, out SHALL load the shadow plus the final bit at that clock edge, out_valid SHALL be high the following cycle for exactly 1 cycle, and the counter SHALL go to 0.
REQ-019 out SHALL hold its value between frames; partial frames never alter out.
REQ-020 In RECV with counter=0, a valid beat with sin_sync=0 SHALL pulse sync_err, move the FSM to HUNT, drop lock, and discard the beat.
REQ-021 In RECV with counter!=0, a valid beat with sin_sync=1 SHALL pulse sync_err, discard the partial frame, and be taken as slot 0 of a new frame (counter=1, the FSM stays in RECV).
REQ-022 Back-to-back frames (valid every cycle) SHALL be supported with no dead cycle; out_valid may pulse every 4th (or 5th) cycle.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set out=4'b0000, out_valid=0, lock=0, sync_err=0, parity_err=0, the FSM to HUNT, the counter to 0, and the shadow to 0.
REQ-024 Reset mid-frame SHALL discard the partial frame, with no out_valid pulse; the first post-reset frame requires sin_sync.

Configuration
REQ-025 With macro TDM_DEMUX_PARITY_EN defined, each frame SHALL carry slot 4, an even-parity bit (XOR of the 4 data bits and the parity bit = 0), and out/out_valid SHALL update on the slot-4 capture instead of slot 3.
REQ-026 With TDM_DEMUX_PARITY_EN defined, on a parity mismatch out SHALL still update, and parity_err SHALL pulse in the same cycle as out_valid.
REQ-027 Without TDM_DEMUX_PARITY_EN, frames SHALL be 4 slots and parity_err SHALL be constant 0.

Verification
REQ-028 Reset, then beats (sync,data) = (1,0),(0,0),(0,1),(0,1) on consecutive cycles -> out=4'b0011, out_valid high exactly 1 cycle, one cycle after the 4th beat, lock=1.
REQ-029 Same frame with 3 idle (sin_valid=0) cycles between every beat -> out=4'b0011, a single out_valid pulse, no sync_err.
REQ-030 After a good frame, the next valid beat has sin_sync=0 -> sync_err pulse, lock=0, and no out_valid until a later sync-led frame completes.
REQ-031 Frame data 1,0 then sin_sync=1 on the 3rd beat followed by 0,1,0 -> sync_err pulse, out=4'b0010 (new frame only).
REQ-032 rst asserted after 2 beats of a frame, then released -> out stays 4'b0000, lock=0, and no out_valid.
REQ-033 With TDM_DEMUX_PARITY_EN: data 1,1,0,1 with parity 0 -> out=4'b1101 and parity_err pulses with out_valid; the same data with parity 1 -> no parity_err.
